iob_ddr_arbiter: RTL and testbench

IOB_DDR_ARBITER -- requirements
Module: iob_ddr_arbiter

---
 rtl/iob_ddr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_iob_ddr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ddr_arbiter.sv
// Two-master round-robin arbiter onto one IOb native memory port, one transaction in flight.
// Optional watchdog enabled by defining IOB_DDR_ARBITER_TIMEOUT_EN.
module iob_ddr_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,

    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_rvalid_o,

    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_rvalid_o,

    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,

    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;      // 1: m1 was served last
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                read_q, read_d;

    logic                pick_m1;
    logic                wdog_fire;
    logic                accept;
    logic                rdone;
    logic                rsp_ready;
    logic                rsp_rvalid;
    logic [DATA_W-1:0]   rsp_rdata;

`ifdef IOB_DDR_ARBITER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    // Fires only when the slave did not complete the step in the same cycle.
    assign wdog_fire = (&wdog_q) &&
                       (((state_q == REQ) && !s_ready_i) ||
                        ((state_q == WAIT_R) && !s_rvalid_i));

    always_comb begin
        wdog_d    = (state_q == IDLE || state_d != state_q) ? '0 : wdog_q + 1'b1;
        timeout_d = timeout_q | wdog_fire;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (cke_i) begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wdog_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // On contention the master not served last wins; a lone requester always wins.
    assign pick_m1 = m1_avalid_i && (!m0_avalid_i || !last_q);

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            read_q  <= 1'b0;
        end else if (cke_i) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            read_q  <= read_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: hold values assigned first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        read_d  = read_q;
        unique case (state_q)
            IDLE: begin
                if (m0_avalid_i || m1_avalid_i) begin
                    state_d = REQ;
                    last_d  = pick_m1;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    addr_d  = pick_m1 ? m1_addr_i  : m0_addr_i;
                    wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
                    wstrb_d = pick_m1 ? m1_wstrb_i : m0_wstrb_i;
                    read_d  = pick_m1 ? ~|m1_wstrb_i : ~|m0_wstrb_i;
                end
            end
            REQ: begin
                if (s_ready_i) begin
                    state_d = (read_q && !s_rvalid_i) ? WAIT_R : IDLE;
                end else if (wdog_fire) begin
                    state_d = IDLE;
                end
            end
            WAIT_R: begin
                if (s_rvalid_i || wdog_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            grant_d = 2'b00;
        end
    end

    // Output logic; handshakes are gated by cke_i so a pulse always coincides with a state step.
    always_comb begin
        accept     = (state_q == REQ) && s_ready_i;
        rdone      = s_rvalid_i && ((accept && read_q) || (state_q == WAIT_R));
        // A WAIT_R timeout already delivered ready, so it only closes the read.
        rsp_ready  = cke_i && (accept || (wdog_fire && state_q == REQ));
        rsp_rvalid = cke_i && (rdone || (wdog_fire && read_q));
        rsp_rdata  = wdog_fire ? '1 : s_rdata_i;

        m0_ready_o  = rsp_ready  && grant_q[0];
        m1_ready_o  = rsp_ready  && grant_q[1];
        m0_rvalid_o = rsp_rvalid && grant_q[0];
        m1_rvalid_o = rsp_rvalid && grant_q[1];
        m0_rdata_o  = m0_rvalid_o ? rsp_rdata : '0;
        m1_rdata_o  = m1_rvalid_o ? rsp_rdata : '0;

        s_avalid_o = (state_q == REQ);
        s_addr_o   = addr_q;
        s_wdata_o  = wdata_q;
        s_wstrb_o  = wstrb_q;
        grant_o    = grant_q;
    end

endmodule

// File: tb/tb_iob_ddr_arbiter.sv
// Directed testbench for iob_ddr_arbiter: write, read, round-robin, clock enable,
// reset mid-transaction and watchdog behaviour.
module tb_iob_ddr_arbiter;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic        m0_avalid_i, m1_avalid_i;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i;
    logic        m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_avalid_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_ready_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    iob_ddr_arbiter dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .m0_avalid_i(m0_avalid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
        .m0_rvalid_o(m0_rvalid_o),
        .m1_avalid_i(m1_avalid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
        .m1_rvalid_o(m1_rvalid_o),
        .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        m0_avalid_i = 1'b1;
        #3;
        tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rst_grant: got %b want 00", grant_o); end
        tests++; if (s_avalid_o !== 1'b0) begin fails++; $display("FAIL rst_s_avalid: got %b want 0", s_avalid_o); end
        tick();
        tick();
        tests++; if ({m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0000) begin
            fails++; $display("FAIL rst_handshakes: got %b want 0000", {m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o}); end
        tests++; if ({s_addr_o, s_wdata_o, s_wstrb_o} !== 68'h0) begin
            fails++; $display("FAIL rst_fields: got %h want 0", {s_addr_o, s_wdata_o, s_wstrb_o}); end
        tests++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
        m0_avalid_i = 1'b0;
        arst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_write();
        m0_avalid_i = 1'b1; m0_addr_i = 32'h100; m0_wdata_i = 32'hCAFEF00D; m0_wstrb_i = 4'hF;
        s_ready_i = 1'b1;
        #1;
        tests++; if (s_avalid_o !== 1'b0) begin fails++; $display("FAIL wr_s_avalid_n: got %b want 0", s_avalid_o); end
        tick();
        tests++; if (s_avalid_o !== 1'b1) begin fails++; $display("FAIL wr_s_avalid_n1: got %b want 1", s_avalid_o); end
        tests++; if ({s_addr_o, s_wdata_o, s_wstrb_o} !== {32'h100, 32'hCAFEF00D, 4'hF}) begin
            fails++; $display("FAIL wr_fields: got %h want %h", {s_addr_o, s_wdata_o, s_wstrb_o}, {32'h100, 32'hCAFEF00D, 4'hF}); end
        tests++; if ({m0_ready_o, m1_ready_o} !== 2'b10) begin
            fails++; $display("FAIL wr_ready: got m0=%b m1=%b want m0=1 m1=0", m0_ready_o, m1_ready_o); end
        tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL wr_grant: got %b want 01", grant_o); end
        tick();
        m0_avalid_i = 1'b0;
        #1;
        tests++; if ({grant_o, s_avalid_o, m0_ready_o} !== 4'b0000) begin
            fails++; $display("FAIL wr_idle: got grant=%b s_avalid=%b m0_ready=%b want 00/0/0", grant_o, s_avalid_o, m0_ready_o); end
        s_ready_i = 1'b0;
    endtask

    task automatic test_read();
        m1_avalid_i = 1'b1; m1_addr_i = 32'h100; m1_wdata_i = 32'h0; m1_wstrb_i = 4'h0;
        s_ready_i = 1'b1;
        tick();
        tests++; if ({m1_ready_o, m0_ready_o, grant_o} !== 4'b1010) begin
            fails++; $display("FAIL rd_accept: got m1_ready=%b m0_ready=%b grant=%b want 1/0/10", m1_ready_o, m0_ready_o, grant_o); end
        tests++; if (s_wstrb_o !== 4'h0) begin fails++; $display("FAIL rd_wstrb: got %h want 0", s_wstrb_o); end
        tick();
        m1_avalid_i = 1'b0;
        #1;
        tests++; if ({m1_ready_o, m1_rvalid_o, grant_o} !== 4'b0010) begin
            fails++; $display("FAIL rd_wait1: got ready=%b rvalid=%b grant=%b want 0/0/10", m1_ready_o, m1_rvalid_o, grant_o); end
        tick();
        tests++; if (m1_rvalid_o !== 1'b0) begin fails++; $display("FAIL rd_wait2: got %b want 0", m1_rvalid_o); end
        tick();
        s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFEF00D;
        #1;
        tests++; if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
            fails++; $display("FAIL rd_data: got rvalid=%b rdata=%h want 1/cafef00d", m1_rvalid_o, m1_rdata_o); end
        tests++; if ({m0_ready_o, m0_rvalid_o, m0_rdata_o} !== 34'h0) begin
            fails++; $display("FAIL rd_m0_quiet: got %h want 0", {m0_ready_o, m0_rvalid_o, m0_rdata_o}); end
        tick();
        tests++; if ({m1_rvalid_o, m1_rdata_o, grant_o} !== 35'h0) begin
            fails++; $display("FAIL rd_late_rvalid: got rvalid=%b rdata=%h grant=%b want 0/0/00", m1_rvalid_o, m1_rdata_o, grant_o); end
        s_rvalid_i = 1'b0; s_rdata_i = 32'h0; s_ready_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_grant;
        logic [31:0] exp_addr;
        m0_avalid_i = 1'b1; m0_addr_i = 32'h200; m0_wdata_i = 32'h11111111; m0_wstrb_i = 4'hF;
        m1_avalid_i = 1'b1; m1_addr_i = 32'h300; m1_wdata_i = 32'h22222222; m1_wstrb_i = 4'h3;
        s_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (i % 2 == 0) ? 32'h200 : 32'h300;
            tick();
            tests++; if ({grant_o, s_addr_o} !== {exp_grant, exp_addr}) begin
                fails++; $display("FAIL rr_grant_%0d: got grant=%b addr=%h want %b/%h", i, grant_o, s_addr_o, exp_grant, exp_addr); end
            tests++; if ({m1_ready_o, m0_ready_o} !== exp_grant) begin
                fails++; $display("FAIL rr_ready_%0d: got %b want %b", i, {m1_ready_o, m0_ready_o}, exp_grant); end
            tick();
            tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rr_idle_%0d: got %b want 00", i, grant_o); end
        end
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0; s_ready_i = 1'b0;
    endtask

    task automatic test_cke();
        m1_avalid_i = 1'b1; m1_addr_i = 32'h44; m1_wdata_i = 32'h55; m1_wstrb_i = 4'h1;
        cke_i = 1'b0;
        tick();
        tests++; if ({s_avalid_o, grant_o} !== 3'b000) begin
            fails++; $display("FAIL cke_idle_hold: got s_avalid=%b grant=%b want 0/00", s_avalid_o, grant_o); end
        cke_i = 1'b1;
        tick();
        cke_i = 1'b0;
        tick();
        tests++; if ({s_avalid_o, grant_o} !== 3'b110) begin
            fails++; $display("FAIL cke_req_hold: got s_avalid=%b grant=%b want 1/10", s_avalid_o, grant_o); end
        cke_i = 1'b1; s_ready_i = 1'b1;
        #1;
        tests++; if (m1_ready_o !== 1'b1) begin fails++; $display("FAIL cke_ready: got %b want 1", m1_ready_o); end
        tick();
        m1_avalid_i = 1'b0; s_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        m0_avalid_i = 1'b1; m0_addr_i = 32'h40; m0_wdata_i = 32'h0; m0_wstrb_i = 4'h0;
        s_ready_i = 1'b1;
        tick();
        tick();
        m0_avalid_i = 1'b0; s_ready_i = 1'b0;
        #1;
        tests++; if ({grant_o, s_avalid_o} !== 3'b010) begin
            fails++; $display("FAIL rm_wait_r: got grant=%b s_avalid=%b want 01/0", grant_o, s_avalid_o); end
        arst_n_i = 1'b0;
        #1;
        tests++; if ({grant_o, s_avalid_o, s_addr_o, m0_ready_o, m0_rvalid_o} !== 37'h0) begin
            fails++; $display("FAIL rm_async: got grant=%b s_avalid=%b addr=%h ready=%b rvalid=%b want all 0",
                              grant_o, s_avalid_o, s_addr_o, m0_ready_o, m0_rvalid_o); end
        s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
        #1;
        tests++; if ({m0_rvalid_o, m0_rdata_o} !== 33'h0) begin
            fails++; $display("FAIL rm_rvalid_in_rst: got %b/%h want 0/0", m0_rvalid_o, m0_rdata_o); end
        tick();
        arst_n_i = 1'b1;
        tick();
        tests++; if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== 34'h0) begin
            fails++; $display("FAIL rm_late_rvalid: got m0=%b m1=%b rdata=%h want 0/0/0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o); end
        s_rvalid_i = 1'b0; s_rdata_i = 32'h0;
        // m0 was served last before reset; reset must hand priority back to m0.
        m0_avalid_i = 1'b1; m0_wstrb_i = 4'hF; m0_addr_i = 32'h500;
        m1_avalid_i = 1'b1; m1_wstrb_i = 4'hF; m1_addr_i = 32'h600;
        s_ready_i = 1'b1;
        tick();
        tests++; if ({grant_o, s_addr_o} !== {2'b01, 32'h500}) begin
            fails++; $display("FAIL rm_priority: got grant=%b addr=%h want 01/00000500", grant_o, s_addr_o); end
        tick();
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0; s_ready_i = 1'b0;
        tick();
    endtask

`ifdef IOB_DDR_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        seen = -1;
        m0_avalid_i = 1'b1; m0_addr_i = 32'h700; m0_wstrb_i = 4'h0;
        s_ready_i = 1'b0;
        tick();
        for (int k = 0; k < 300 && seen < 0; k++) begin
            if (m0_ready_o === 1'b1) begin
                seen = k;
                tests++; if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'hFFFFFFFF}) begin
                    fails++; $display("FAIL to_rdata: got %b/%h want 1/ffffffff", m0_rvalid_o, m0_rdata_o); end
            end else begin
                tick();
            end
        end
        tests++; if (seen != 255) begin fails++; $display("FAIL to_latency: got %0d want 255", seen); end
        tick();
        m0_avalid_i = 1'b0;
        tick();
        tick();
        tests++; if ({timeout_o, s_avalid_o, grant_o} !== 4'b1000) begin
            fails++; $display("FAIL to_sticky: got timeout=%b s_avalid=%b grant=%b want 1/0/00", timeout_o, s_avalid_o, grant_o); end
    endtask
`else
    task automatic test_timeout();
        m1_avalid_i = 1'b1; m1_addr_i = 32'h80; m1_wdata_i = 32'h1; m1_wstrb_i = 4'hF;
        s_ready_i = 1'b0;
        tick();
        repeat (1000) tick();
        tests++; if ({s_avalid_o, grant_o, m1_ready_o, timeout_o} !== 5'b11000) begin
            fails++; $display("FAIL nto_wait: got s_avalid=%b grant=%b ready=%b timeout=%b want 1/10/0/0",
                              s_avalid_o, grant_o, m1_ready_o, timeout_o); end
        m1_avalid_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout want completion");
        $fatal(1);
    end

    initial begin
        cke_i = 1'b1;
        m0_avalid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
        m1_avalid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
        s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_cke();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
